// File: rtl/rptr_empty_if.sv
// Read-side FIFO pointer bundle: read request/status toward the read port
// and the synchronized write pointer coming from the write domain.
interface rptr_empty_if #(
    parameter int unsigned ADDR_SIZE = 4
);
    logic                 rd_inc;
    logic [ADDR_SIZE:0]   rdq2_wptr;
    logic                 rd_err_clr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE:0]   rd_ptr;
    logic                 rd_empty;
    logic                 rd_aempty;
    logic [ADDR_SIZE:0]   rd_level;
    logic                 rd_underflow;

    modport master (
        output rd_inc, rdq2_wptr, rd_err_clr,
        input  rd_addr, rd_ptr, rd_empty, rd_aempty, rd_level, rd_underflow
    );

    modport slave (
        input  rd_inc, rdq2_wptr, rd_err_clr,
        output rd_addr, rd_ptr, rd_empty, rd_aempty, rd_level, rd_underflow
    );
endinterface

// File: rtl/rptr_empty.sv
// Async FIFO read-side pointer: binary/Gray read pointer, registered empty,
// almost-empty, occupancy level and sticky underflow, all in the rd_clk domain.
module rptr_empty #(
    parameter int unsigned ADDR_SIZE     = 4,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic        rd_clk,
    input  logic        rd_rstn,
    rptr_empty_if.slave bus
);
    localparam int unsigned   PW     = ADDR_SIZE + 1;
    localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] rd_level_q;
    logic          rd_empty_q;
    logic          rd_aempty_q;
    logic          rd_underflow_q;

    logic          rd_accept_c;
    logic [PW-1:0] rd_binnext;
    logic [PW-1:0] rd_graynext;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;
    logic          empty_val;
    logic          aempty_val;
    logic          underflow_next;

    // Next pointer: only reads that arrive while non-empty advance it.
    assign rd_accept_c = bus.rd_inc & ~rd_empty_q;
    assign rd_binnext  = rd_bin + PW'(rd_accept_c);
    assign rd_graynext = (rd_binnext >> 1) ^ rd_binnext;

    // Gray-to-binary of the synchronized write pointer: each bit is the
    // parity of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(bus.rdq2_wptr >> i);
        end
    end

    assign level_next     = wbin - rd_binnext;
    assign empty_val      = (rd_graynext == bus.rdq2_wptr);
    assign aempty_val     = (level_next <= THRESH);
    assign underflow_next = (bus.rd_inc & rd_empty_q) | (rd_underflow_q & ~bus.rd_err_clr);

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_bin         <= '0;
            rd_gray        <= '0;
            rd_empty_q     <= 1'b1;
            rd_aempty_q    <= 1'b1;
            rd_level_q     <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            rd_bin         <= rd_binnext;
            rd_gray        <= rd_graynext;
            rd_empty_q     <= empty_val;
            rd_aempty_q    <= aempty_val;
            rd_level_q     <= level_next;
            rd_underflow_q <= underflow_next;
        end
    end

    assign bus.rd_addr      = rd_bin[ADDR_SIZE-1:0];
    assign bus.rd_ptr       = rd_gray;
    assign bus.rd_empty     = rd_empty_q;
    assign bus.rd_aempty    = rd_aempty_q;
    assign bus.rd_level     = rd_level_q;
    assign bus.rd_underflow = rd_underflow_q;
endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: write/read counts kept as plain integers; expected
// outputs derived from their difference and modular truncation.
module tb_rptr_empty;
    localparam int AW = 4;
    localparam int TH = 2;

    logic rd_clk;
    logic rd_rstn;

    rptr_empty_if #(.ADDR_SIZE(AW)) bus ();

    rptr_empty #(.ADDR_SIZE(AW), .AEMPTY_THRESH(TH)) dut (
        .rd_clk  (rd_clk),
        .rd_rstn (rd_rstn),
        .bus     (bus.slave)
    );

    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    int vecs = 0;
    int errs = 0;

    // Reference state: total reads accepted, total writes visible, flags.
    int   m_rd;
    int   m_w;
    int   m_level;
    logic m_empty;
    logic m_aempty;
    logic m_uf;

    localparam logic [16:0] RST_VEC = {4'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0};

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [16:0] obs_vec();
        return {bus.rd_addr, bus.rd_ptr, bus.rd_empty, bus.rd_aempty, bus.rd_level, bus.rd_underflow};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {4'(m_rd), gray5(m_rd), m_empty, m_aempty, 5'(m_level), m_uf};
    endfunction

    task automatic model_reset();
        m_rd = 0; m_w = 0; m_level = 0;
        m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    endtask

    // One rd_clk cycle: drive at negedge, advance the model at posedge, settle.
    task automatic cyc(input logic inc, input logic clr, input int w);
        @(negedge rd_clk);
        bus.rd_inc     = inc;
        bus.rd_err_clr = clr;
        bus.rdq2_wptr  = gray5(w);
        @(posedge rd_clk);
        m_uf = (inc && m_empty) || (m_uf && !clr);
        if (inc && !m_empty) m_rd++;
        m_w      = w;
        m_level  = m_w - m_rd;
        m_empty  = (m_level == 0);
        m_aempty = (m_level <= TH);
        #1;
    endtask

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rstn = 1'b0;
        bus.rd_inc = 1'b0; bus.rd_err_clr = 1'b0; bus.rdq2_wptr = '0;
        model_reset();
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        rd_rstn = 1'b1;
    endtask

    task automatic test_reset();
        rd_rstn = 1'b0;
        bus.rd_inc = 1'b1; bus.rd_err_clr = 1'b0; bus.rdq2_wptr = gray5(7);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            vecs++;
            if (obs_vec() !== RST_VEC) begin
                errs++; $display("FAIL reset_hold[%0d]: got %h want %h", i, obs_vec(), RST_VEC);
            end
        end
        bus.rd_inc = 1'b0; bus.rdq2_wptr = '0;
        rd_rstn = 1'b1;
        cyc(1'b0, 1'b0, 0);
        vecs++;
        if (obs_vec() !== exp_vec()) begin
            errs++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_drain();
        cyc(1'b0, 1'b0, 3);
        vecs++;
        if (bus.rd_level !== 5'd3 || bus.rd_empty !== 1'b0 || bus.rd_aempty !== 1'b0) begin
            errs++; $display("FAIL drain_fill: got lvl=%0d e=%b ae=%b want lvl=3 e=0 ae=0",
                             bus.rd_level, bus.rd_empty, bus.rd_aempty);
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (bus.rd_addr !== 4'(i)) begin
                errs++; $display("FAIL drain_addr[%0d]: got %0d want %0d", i, bus.rd_addr, i);
            end
            cyc(1'b1, 1'b0, 3);
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                errs++; $display("FAIL drain_step[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        vecs++;
        if (bus.rd_ptr !== 5'b00010 || bus.rd_empty !== 1'b1) begin
            errs++; $display("FAIL drain_final: got ptr=%b e=%b want ptr=00010 e=1", bus.rd_ptr, bus.rd_empty);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, m_w);
            vecs++;
            if (obs_vec() !== exp_vec() || bus.rd_underflow !== 1'b1) begin
                errs++; $display("FAIL uf_set[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cyc(1'b1, 1'b1, m_w);
        vecs++;
        if (bus.rd_underflow !== 1'b1 || obs_vec() !== exp_vec()) begin
            errs++; $display("FAIL uf_set_vs_clr: got %h want %h", obs_vec(), exp_vec());
        end
        cyc(1'b0, 1'b1, m_w);
        vecs++;
        if (bus.rd_underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
            errs++; $display("FAIL uf_clear: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full_level();
        do_reset();
        cyc(1'b0, 1'b0, 16);
        vecs++;
        if (bus.rd_level !== 5'd16 || bus.rd_empty !== 1'b0) begin
            errs++; $display("FAIL full_level: got lvl=%0d e=%b want lvl=16 e=0", bus.rd_level, bus.rd_empty);
        end
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 16);
            vecs++;
            if (obs_vec() !== exp_vec() || bus.rd_empty !== (i == 16)) begin
                errs++; $display("FAIL full_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_concurrent();
        cyc(1'b0, 1'b0, m_w + 4);
        vecs++;
        if (bus.rd_level !== 5'd4) begin
            errs++; $display("FAIL conc_setup: got lvl=%0d want 4", bus.rd_level);
        end
        cyc(1'b1, 1'b0, m_w + 1);
        vecs++;
        if (bus.rd_level !== 5'd4 || obs_vec() !== exp_vec()) begin
            errs++; $display("FAIL conc_read_write: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        int w;
        int wraps;
        int cap;
        logic [3:0] prev_addr;
        do_reset();
        w = 0; wraps = 0; prev_addr = '0;
        for (int c = 0; c < 600 && m_rd < 40; c++) begin
            cap = m_rd + 16;
            if (cap > 40) cap = 40;
            w = w + int'($urandom_range(0, 2));
            if (w > cap) w = cap;
            cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), w);
            vecs++;
            if (obs_vec() !== exp_vec()) begin
                errs++; $display("FAIL wrap_cycle[%0d]: got %h want %h", c, obs_vec(), exp_vec());
            end
            if (prev_addr == 4'd15 && bus.rd_addr == 4'd0) wraps++;
            prev_addr = bus.rd_addr;
        end
        vecs++;
        if (m_rd != 40) begin
            errs++; $display("FAIL wrap_timeout: got %0d reads want 40", m_rd);
        end
        vecs++;
        if (wraps != 2 || bus.rd_ptr !== 5'b01100) begin
            errs++; $display("FAIL wrap_count: got wraps=%0d ptr=%b want wraps=2 ptr=01100", wraps, bus.rd_ptr);
        end
    endtask

    task automatic test_reset_midstream();
        cyc(1'b0, 1'b0, m_w + 5);
        cyc(1'b1, 1'b0, m_w);
        @(negedge rd_clk);
        bus.rd_inc = 1'b1;
        #2 rd_rstn = 1'b0;
        #1;
        vecs++;
        if (obs_vec() !== RST_VEC) begin
            errs++; $display("FAIL reset_async: got %h want %h", obs_vec(), RST_VEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            vecs++;
            if (obs_vec() !== RST_VEC) begin
                errs++; $display("FAIL reset_mid_hold[%0d]: got %h want %h", i, obs_vec(), RST_VEC);
            end
        end
        bus.rd_inc = 1'b0; bus.rdq2_wptr = '0;
        model_reset();
        rd_rstn = 1'b1;
        cyc(1'b1, 1'b0, 0);
        vecs++;
        if (obs_vec() !== exp_vec()) begin
            errs++; $display("FAIL reset_mid_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_underflow();
        test_full_level();
        test_concurrent();
        test_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
